serial_sub: RTL and testbench
=============================

# serial_sub

Bit-serial subtractor: accepts two WIDTH-bit operands and a borrow-in over a valid/ready handshake, computes `a - b - bin` LSB-first, one bit per clock, through a single full-subtractor cell and a borrow flip-flop. It returns the difference and borrow-out over a second valid/ready handshake. It is the subtract-direction counterpart of the `fa`/`ha` adder cells and serves area-constrained datapaths that trade latency for a single 1-bit cell.

## Interface
- `WIDTH`, 8: operand and result width; legal range ≥ 1.
- `delay`, 0: gate delay forwarded to the `fs` cell; simulation only.

Ports:
- `clk` input 1: the single clock; all state updates on its rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: operands are presented.
- `in_ready` output 1: block can accept an operand set.
- `a` input WIDTH: minuend.
- `b` input WIDTH: subtrahend.
- `bin` input 1: borrow-in.
- `out_valid` output 1: result is available.
- `out_ready` input 1: consumer takes the result.
- `d` output WIDTH: difference, `(a - b - bin) mod 2^WIDTH`.
- `bout` output 1: borrow-out; 1 exactly when `a < b + bin` as unsigned values.

## Operation
- The FSM has three states:
  - IDLE: `in_ready=1`, `out_valid=0`.
  - BUSY: both 0.
  - DONE: `in_ready=0`, `out_valid=1`.
- IDLE → BUSY on `in_valid && in_ready`. On that edge:
  - `a` and `b` are copied into shift registers.
  - The borrow flip-flop is loaded with `bin`.
  - The bit counter is cleared to 0.
- BUSY: on each edge the `fs` cell consumes bit 0 of both shift registers and the current borrow:
  - `d_bit = a0 ^ b0 ^ br`
  - `br_next = (~a0 & b0) | (~(a0 ^ b0) & br)`
  - `d_bit` is shifted into the MSB of the result register, which fills from the top.
  - Both operand registers shift right by one.
  - The counter increments.
- BUSY → DONE on the edge that processes bit WIDTH-1 (counter == WIDTH-1). The result register then holds `d`, and the borrow flip-flop is latched as `bout`.
- DONE → IDLE on `out_valid && out_ready`.
- `d` and `bout` hold their last values until the next result is written.
- Inputs are ignored outside IDLE; `in_valid` is not a request queue.
- Arithmetic is unsigned modulo 2^WIDTH. There is no overflow flag beyond `bout`.

## Timing
- Reset values (asynchronous, while `rst_n=0`): state IDLE, `in_ready=1`, `out_valid=0`, `d=0`, `bout=0`, counter 0, borrow 0.
- Latency: the accept edge is T; `out_valid` goes high after edge T+WIDTH.
- Throughput with `out_ready` held high: DONE → IDLE at T+WIDTH+1, next accept at T+WIDTH+2. The sustained period is WIDTH+2 cycles.
- `in_ready` and `out_valid` are decoded from registered state only. There is no combinational path from `in_valid` or `out_ready` to any output.
- `out_ready` already high when DONE is entered: the transfer completes on the first DONE edge.
- Backpressure: `d`, `bout` and `out_valid` are stable while `out_ready=0`, indefinitely.
- No accept occurs on the same edge as a result transfer. The DONE → IDLE edge never loads operands.
- Reset asserted mid-BUSY or mid-DONE: the transaction is discarded and outputs take reset values immediately. The first operation after deassertion is exact.
- WIDTH=1: BUSY lasts exactly one edge. The counter is `$clog2(WIDTH+1)` bits wide, so it never wraps before the compare.

## Structure
- Package `serial_pkg` holds:
  - `typedef enum logic [1:0] {IDLE, BUSY, DONE} serial_state_t`.
  - Any shared bit-serial constants, for reuse by a future serial adder.
- Sub-module `fs (input a, input b, input bi, output d, output bo)`: combinational full subtractor with parameter `delay`. It is built from two half-subtractor stages plus an `or`, mirroring the `fa`/`ha` construction. It is the only per-bit logic instantiated.
- Top level contains the FSM, counter, two operand shift registers, result shift register and borrow flip-flop.

## Test plan
- Basic subtract: WIDTH=8, `a=0x5A`, `b=0x23`, `bin=0` → `out_valid` rises 8 cycles after the accept edge; `d=0x37`, `bout=0`.
- Underflow: `a=0x00`, `b=0x01`, `bin=0` → `d=0xFF`, `bout=1`. Also `a=0x80`, `b=0x80`, `bin=1` → `d=0xFF`, `bout=1`.
- Backpressure: hold `out_ready=0` for 5 cycles after `out_valid` rises → `d`, `bout` and `out_valid` stay constant and `in_ready=0`. A new `in_valid` pulse during this time is ignored.
- Back-to-back: `out_ready` tied high, operand pairs (0x10,0x01) then (0x01,0x10) → results 0x0F/`bout=0` then 0xF1/`bout=1`, accepts spaced exactly 10 cycles apart.
- Reset mid-operation: drop `rst_n` on the 3rd BUSY cycle → `out_valid=0` and `in_ready=1` immediately. Next op `a=0xFF`, `b=0xFF`, `bin=1` → `d=0xFF`, `bout=1`.
- Exhaustive cross-check: WIDTH=4, all `a`, `b`, `bin` combinations → every `{bout,d}` equals `{a - b - bin}` computed 5 bits wide.

Source files
------------

// File: rtl/serial_pkg.sv
// serial_pkg: shared types and constants for bit-serial arithmetic blocks.
//   serial_state_t     - handshake FSM states shared by serial adders/subtractors
//   serial_count_width - width of a bit counter that must reach WIDTH without wrapping
package serial_pkg;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} serial_state_t;

    // One result bit is produced per clock by every serial cell in this family.
    localparam int SERIAL_BITS_PER_CYCLE = 1;

    function automatic int serial_count_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/serial_sub_fs.sv
// fs: combinational 1-bit full subtractor, d = a - b - bi, bo = borrow out.
//   a, b  - minuend / subtrahend bits
//   bi    - borrow in
//   d, bo - difference bit / borrow out
// Built from two half-subtractor stages joined by an OR, the subtract-side
// mirror of the fa/ha adder construction.
module fs #(
    parameter int delay = 0
) (
    input  logic a,
    input  logic b,
    input  logic bi,
    output logic d,
    output logic bo
);

    logic d1;
    logic b1;
    logic b2;

    // delay only shapes the gate-level simulation models of this cell family;
    // the synthesizable cell carries no timing of its own.
    logic unused_delay;
    assign unused_delay = (delay != 0);

    // First half subtractor: a - b
    assign d1 = a ^ b;
    assign b1 = ~a & b;

    // Second half subtractor: (a - b) - bi
    assign d  = d1 ^ bi;
    assign b2 = ~d1 & bi;

    assign bo = b1 | b2;

endmodule

// File: rtl/serial_sub.sv
// serial_sub: bit-serial subtractor, (a - b - bin) computed LSB-first, one bit
// per clock, through a single fs cell and a borrow flip-flop.
//   clk, rst_n           - clock, asynchronous active-low reset
//   in_valid / in_ready  - operand handshake (a, b, bin)
//   out_valid / out_ready- result handshake (d, bout)
//   d                    - (a - b - bin) mod 2^WIDTH
//   bout                 - 1 when a < b + bin (unsigned)
module serial_sub
    import serial_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int delay = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] d,
    output logic             bout
);

    localparam int            CW   = serial_count_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    serial_state_t    state;
    serial_state_t    state_next;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] r_sh;
    logic             br;
    logic             d_bit;
    logic             br_next;
    logic             accept;
    logic             last;
    logic [WIDTH:0]   r_cat;

    fs #(.delay(delay)) u_fs (
        .a  (a_sh[0]),
        .b  (b_sh[0]),
        .bi (br),
        .d  (d_bit),
        .bo (br_next)
    );

    assign accept = in_valid && in_ready;
    assign last   = (count == LAST);
    // New bit enters at the MSB; dropping the LSB of {d_bit, r_sh} is the
    // right shift, and stays legal for WIDTH == 1.
    assign r_cat  = {d_bit, r_sh};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Handshake outputs depend on the registered state only.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = BUSY;
            end
            BUSY: begin
                if (last) state_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            br    <= 1'b0;
            d     <= '0;
            bout  <= 1'b0;
        end else if (accept) begin
            count <= '0;
            br    <= bin;
        end else if (state == BUSY) begin
            count <= count + CW'(1);
            br    <= br_next;
            // d is only written when the full result is ready, so it holds
            // the previous result throughout the next BUSY phase.
            if (last) begin
                d    <= r_cat[WIDTH:1];
                bout <= br_next;
            end
        end
    end

    // Shift registers are fully reloaded or overwritten before use.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_sh <= a;
            b_sh <= b;
        end else if (state == BUSY) begin
            a_sh <= a_sh >> 1;
            b_sh <= b_sh >> 1;
            r_sh <= r_cat[WIDTH:1];
        end
    end

endmodule

// File: tb/tb_serial_sub.sv
`timescale 1ns/1ps
module tb_serial_sub;

    logic       clk = 1'b0;
    logic       rst_n;

    logic       in_valid8, in_ready8, bin8, out_valid8, out_ready8, bout8;
    logic [7:0] a8, b8, d8;
    logic       in_valid4, in_ready4, bin4, out_valid4, out_ready4, bout4;
    logic [3:0] a4, b4, d4;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int acc8  = 0;
    int prev_acc8 = 0;
    int acc4  = 0;
    logic ov8_prev = 1'b0;
    logic ov4_prev = 1'b0;
    logic [8:0] q8[$];
    logic [4:0] q4[$];

    serial_sub #(.WIDTH(8), .delay(0)) dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .bin(bin8),
        .out_valid(out_valid8), .out_ready(out_ready8),
        .d(d8), .bout(bout8)
    );

    serial_sub #(.WIDTH(4), .delay(0)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid4), .in_ready(in_ready4),
        .a(a4), .b(b4), .bin(bin4),
        .out_valid(out_valid4), .out_ready(out_ready4),
        .d(d4), .bout(bout4)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboard monitors: a result is taken when valid && ready at the next edge.
    always @(negedge clk) begin
        logic [8:0] e8;
        if (rst_n) begin
            if (out_valid8 && !ov8_prev) check("lat8", cyc - acc8, 8);
            if (out_valid8 && out_ready8) begin
                if (q8.size() == 0) check("sb8_unexpected", q8.size(), 1);
                else begin
                    e8 = q8.pop_front();
                    check("res8", {bout8, d8}, e8);
                end
            end
        end
        ov8_prev = out_valid8;
    end

    always @(negedge clk) begin
        logic [4:0] e4;
        if (rst_n) begin
            if (out_valid4 && !ov4_prev) check("lat4", cyc - acc4, 4);
            if (out_valid4 && out_ready4) begin
                if (q4.size() == 0) check("sb4_unexpected", q4.size(), 1);
                else begin
                    e4 = q4.pop_front();
                    check("res4", {bout4, d4}, e4);
                end
            end
        end
        ov4_prev = out_valid4;
    end

    task automatic send8(input logic [7:0] a, input logic [7:0] b, input logic bin);
        int g = 0;
        while (!in_ready8 && g < 200) begin
            @(posedge clk); #1;
            g++;
        end
        if (!in_ready8) begin
            check("timeout_in_ready8", in_ready8, 1);
            return;
        end
        a8 = a; b8 = b; bin8 = bin; in_valid8 = 1'b1;
        prev_acc8 = acc8;
        acc8 = cyc + 1;
        q8.push_back({1'b0, a} - {1'b0, b} - 9'(bin));
        @(posedge clk); #1;
        in_valid8 = 1'b0;
    endtask

    initial begin
        int g;
        rst_n = 1'b0;
        in_valid8 = 0; a8 = '0; b8 = '0; bin8 = 0; out_ready8 = 1;
        in_valid4 = 0; a4 = '0; b4 = '0; bin4 = 0; out_ready4 = 1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready8, 1);
        check("rst_out_valid", out_valid8, 0);
        check("rst_d", d8, 8'h00);
        check("rst_bout", bout8, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic and underflow cases
        send8(8'h5A, 8'h23, 1'b0);
        send8(8'h00, 8'h01, 1'b0);
        send8(8'h80, 8'h80, 1'b1);

        // Backpressure with an ignored in_valid pulse while DONE
        g = 0;
        while (!in_ready8 && g < 50) begin @(posedge clk); #1; g++; end
        out_ready8 = 1'b0;
        send8(8'h0F, 8'h3C, 1'b0);
        g = 0;
        while (!out_valid8 && g < 40) begin @(posedge clk); #1; g++; end
        check("bp_valid_rise", out_valid8, 1);
        for (int i = 0; i < 5; i++) begin
            if (i == 1) begin a8 = 8'hAA; b8 = 8'h55; in_valid8 = 1'b1; end
            else in_valid8 = 1'b0;
            @(posedge clk); #1;
            check("bp_valid", out_valid8, 1);
            check("bp_d", d8, 8'hD3);
            check("bp_bout", bout8, 1);
            check("bp_in_ready", in_ready8, 0);
        end
        in_valid8 = 1'b0;
        out_ready8 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("bp_ignored_in_ready", in_ready8, 1);
        check("bp_ignored_out_valid", out_valid8, 0);

        // Back-to-back with out_ready held high
        send8(8'h10, 8'h01, 1'b0);
        send8(8'h01, 8'h10, 1'b0);
        check("b2b_spacing", acc8 - prev_acc8, 10);

        // Reset in the third BUSY cycle
        g = 0;
        while (!in_ready8 && g < 50) begin @(posedge clk); #1; g++; end
        send8(8'h77, 8'h11, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", out_valid8, 0);
        check("mid_rst_in_ready", in_ready8, 1);
        check("mid_rst_d", d8, 8'h00);
        check("mid_rst_bout", bout8, 0);
        q8.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        send8(8'hFF, 8'hFF, 1'b1);

        // Exhaustive WIDTH=4 cross-check
        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                for (int ic = 0; ic < 2; ic++) begin
                    g = 0;
                    while (!in_ready4 && g < 20) begin @(posedge clk); #1; g++; end
                    if (!in_ready4) check("timeout_in_ready4", in_ready4, 1);
                    a4 = ia[3:0]; b4 = ib[3:0]; bin4 = ic[0]; in_valid4 = 1'b1;
                    acc4 = cyc + 1;
                    q4.push_back({1'b0, ia[3:0]} - {1'b0, ib[3:0]} - 5'(ic));
                    @(posedge clk); #1;
                    in_valid4 = 1'b0;
                end
            end
        end

        g = 0;
        while ((q8.size() != 0 || q4.size() != 0) && g < 100) begin @(posedge clk); #1; g++; end
        check("drain8", q8.size(), 0);
        check("drain4", q4.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
